// File: rtl/modexp_pkg.sv
// Shared encodings for the modular-exponentiation controller: phase/substate
// codes and operand-mux selects.
package modexp_pkg;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PRE  = 3'd1;
    localparam state_t ST_LOOP = 3'd2;
    localparam state_t ST_POST = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    typedef logic [1:0] sub_t;
    localparam sub_t SUB_IDLE  = 2'd0;
    localparam sub_t SUB_LOAD  = 2'd1;
    localparam sub_t SUB_WAIT  = 2'd2;
    localparam sub_t SUB_STORE = 2'd3;

    localparam logic [1:0] SEL1_PRE  = 2'b00;
    localparam logic [1:0] SEL1_LOOP = 2'b01;
    localparam logic [1:0] SEL1_POST = 2'b10;

    function automatic logic is_round(input state_t s);
        return (s == ST_PRE) || (s == ST_LOOP) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/modexp_if.sv
// Handshake and datapath-control bundle between the register wrapper /
// multiplier side (master) and modexp_ctrl (slave).
interface modexp_if #(parameter int EXP_W = 16);
    logic             start;
    logic [EXP_W-1:0] exp_e;
    logic             mmm_done;
    logic             mmm_start;
    logic             rst_mmm;
    logic             ld_a;
    logic             ld_r;
    logic             lock1;
    logic             lock2;
    logic [1:0]       sel1;
    logic             sel2;
    logic             busy;
    logic             eoc;

    modport master (
        output start, exp_e, mmm_done,
        input  mmm_start, rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc
    );

    modport slave (
        input  start, exp_e, mmm_done,
        output mmm_start, rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc
    );
endinterface

// File: rtl/modexp_round_seq.sv
// One multiplier round: LOAD (launch) -> WAIT (for mmm_done) -> STORE.
// Decodes are combinational; the top level registers them onto the pins.
module modexp_round_seq
    import modexp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic go,
    input  logic mmm_done,
    output logic ld_a,
    output logic mmm_start,
    output logic ld_r,
    output logic round_done
);

    sub_t sub, sub_nx;

    always_comb begin
        sub_nx = sub;
        case (sub)
            SUB_IDLE:  if (go) sub_nx = SUB_LOAD;
            SUB_LOAD:  sub_nx = SUB_WAIT;
            SUB_WAIT:  if (mmm_done) sub_nx = SUB_STORE;
            SUB_STORE: sub_nx = go ? SUB_LOAD : SUB_IDLE;
            default:   sub_nx = SUB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub <= SUB_IDLE;
        end else if (en) begin
            sub <= sub_nx;
        end
    end

    assign ld_a       = (sub == SUB_LOAD);
    assign mmm_start  = (sub == SUB_LOAD);
    assign ld_r       = (sub == SUB_STORE);
    assign round_done = (sub == SUB_STORE);

endmodule

// File: rtl/modexp_ctrl.sv
// Phase controller for Montgomery modular exponentiation (PRE, EXP_W LSB-first
// rounds, POST). Define MODEXP_EARLY_EXIT_EN to leave LOOP once exp_sr is zero.
//
// state   | meaning
// IDLE    | waiting for start; exponent captured on accept
// PRE     | one round converting operands into Montgomery domain
// LOOP    | one square/multiply round per exponent bit
// POST    | one round converting the result back
// DONE    | single-cycle end-of-conversion
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int EXP_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    modexp_if.slave   bus
);

    localparam int CNT_W = $clog2(EXP_W + 1);

    state_t           state, state_nx;
    logic [EXP_W-1:0] exp_sr, sr_shift;
    logic [CNT_W-1:0] bit_cnt, cnt_inc;
    logic             go, loop_exit, skip_loop;
    logic             seq_ld_a, seq_start, seq_ld_r, round_done;

    assign sr_shift = exp_sr >> 1;
    assign cnt_inc  = bit_cnt + 1'b1;

`ifdef MODEXP_EARLY_EXIT_EN
    assign loop_exit = (cnt_inc == CNT_W'(EXP_W)) || (sr_shift == '0);
    assign skip_loop = (exp_sr == '0);
`else
    assign loop_exit = (cnt_inc == CNT_W'(EXP_W));
    assign skip_loop = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_PRE;
            ST_PRE:  if (round_done) state_nx = skip_loop ? ST_POST : ST_LOOP;
            ST_LOOP: if (round_done && loop_exit) state_nx = ST_POST;
            ST_POST: if (round_done) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Relaunch the round sequencer on the same edge as the phase change so rounds run back to back.
    assign go = ((state == ST_IDLE) && bus.start) || (round_done && is_round(state_nx));

    modexp_round_seq u_seq (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .go         (go),
        .mmm_done   (bus.mmm_done),
        .ld_a       (seq_ld_a),
        .mmm_start  (seq_start),
        .ld_r       (seq_ld_r),
        .round_done (round_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            exp_sr        <= '0;
            bit_cnt       <= '0;
            bus.mmm_start <= 1'b0;
            bus.rst_mmm   <= 1'b0;
            bus.ld_a      <= 1'b0;
            bus.ld_r      <= 1'b0;
            bus.lock1     <= 1'b0;
            bus.lock2     <= 1'b0;
            bus.sel1      <= SEL1_PRE;
            bus.sel2      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.eoc       <= 1'b0;
        end else if (en) begin
            state <= state_nx;
            if ((state == ST_IDLE) && bus.start) begin
                exp_sr  <= bus.exp_e;
                bit_cnt <= '0;
            end else if ((state == ST_LOOP) && round_done) begin
                exp_sr  <= sr_shift;
                bit_cnt <= cnt_inc;
            end

            // Pins reflect the current phase one cycle later; lock1 is taken before the shift.
            bus.mmm_start <= seq_start;
            bus.ld_a      <= seq_ld_a;
            bus.ld_r      <= seq_ld_r;
            bus.busy      <= (state != ST_IDLE);
            bus.rst_mmm   <= is_round(state);
            bus.eoc       <= (state == ST_DONE);
            case (state)
                ST_PRE: begin
                    bus.sel1 <= SEL1_PRE;  bus.sel2 <= 1'b0;
                    bus.lock1 <= 1'b1;     bus.lock2 <= 1'b1;
                end
                ST_LOOP: begin
                    bus.sel1 <= SEL1_LOOP; bus.sel2 <= 1'b1;
                    bus.lock1 <= exp_sr[0]; bus.lock2 <= 1'b1;
                end
                ST_POST: begin
                    bus.sel1 <= SEL1_POST; bus.sel2 <= 1'b1;
                    bus.lock1 <= 1'b1;     bus.lock2 <= 1'b0;
                end
                default: begin
                    bus.sel1 <= SEL1_PRE;  bus.sel2 <= 1'b0;
                    bus.lock1 <= 1'b0;     bus.lock2 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl (EXP_W=8) with a fixed-latency multiplier model
// whose rounds last 5 cycles.
module tb_modexp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic mul_done = 1'b0;
    logic stray_done = 1'b0;
    logic en_s, rst_s;
    int   mcnt = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    modexp_if #(.EXP_W(8)) bus ();
    assign bus.mmm_done = mul_done | stray_done;

    modexp_ctrl #(.EXP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    // Multiplier: raises done in the third WAIT cycle after launch; shares en.
    always @(posedge clk) begin
        en_s  = en;
        rst_s = rst;
        #1;
        if (rst_s) begin
            mcnt     = 0;
            mul_done = 1'b0;
        end else if (en_s) begin
            mul_done = 1'b0;
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) mul_done = 1'b1;
            end
            if (bus.mmm_start) mcnt = 2;
        end
    end

    typedef struct {
        logic [7:0] e;
        int         eoc;
        int         ldr;
        int         nloop;
        logic [7:0] lock1;
    } vec_t;

    vec_t vecs [5];

`ifdef MODEXP_EARLY_EXIT_EN
    localparam int EOC_05 = 26;
`else
    localparam int EOC_05 = 51;
`endif

    function automatic logic [10:0] outs();
        return {bus.mmm_start, bus.rst_mmm, bus.ld_a, bus.ld_r, bus.lock1, bus.lock2,
                bus.sel1, bus.sel2, bus.busy, bus.eoc};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Runs one operation; k counts cycles after the start-sampling edge.
    task automatic run_op(input logic [7:0] e, input bit hold, input int stray_start_k,
                          input int stray_done_k, input int en_off_k, input int rst_k,
                          output int eoc_at, output int n_ldr, output int n_loop,
                          output logic [7:0] l1, output int n_busy, output int frozen_bad,
                          output logic [10:0] rst_outs);
        logic [10:0] snap;
        eoc_at = -1; n_ldr = 0; n_loop = 0; l1 = '0; n_busy = 0; frozen_bad = 0;
        rst_outs = '1; snap = '0;
        bus.exp_e = e;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = hold;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (rst_k > 0 && k == rst_k + 1) begin
                rst_outs = outs();
                rst = 1'b0;
                return;
            end
            if (bus.ld_r) n_ldr++;
            if (bus.ld_r && bus.sel1 == 2'b01) begin
                if (n_loop < 8) l1[n_loop[2:0]] = bus.lock1;
                n_loop++;
            end
            if (bus.busy) n_busy++;
            if (en_off_k > 0 && k == en_off_k) snap = outs();
            if (en_off_k > 0 && k > en_off_k && k <= en_off_k + 4 && outs() != snap) frozen_bad++;
            bus.start  = hold || (k == stray_start_k);
            stray_done = (k == stray_done_k);
            en         = !(en_off_k > 0 && k >= en_off_k && k < en_off_k + 4);
            rst        = (rst_k > 0 && k == rst_k);
            if (bus.eoc) begin
                eoc_at = k;
                break;
            end
        end
    endtask

    initial begin
        int eoc_at, n_ldr, n_loop, n_busy, frozen_bad, got;
        logic [7:0] l1;
        logic [10:0] ro;

`ifdef MODEXP_EARLY_EXIT_EN
        vecs[0] = '{8'h05, 26,  5, 3, 8'h05};
        vecs[1] = '{8'h00, 11,  2, 0, 8'h00};
        vecs[2] = '{8'hFF, 51, 10, 8, 8'hFF};
        vecs[3] = '{8'h80, 51, 10, 8, 8'h80};
        vecs[4] = '{8'h01, 16,  3, 1, 8'h01};
`else
        vecs[0] = '{8'h05, 51, 10, 8, 8'h05};
        vecs[1] = '{8'h00, 51, 10, 8, 8'h00};
        vecs[2] = '{8'hFF, 51, 10, 8, 8'hFF};
        vecs[3] = '{8'h80, 51, 10, 8, 8'h80};
        vecs[4] = '{8'h01, 51, 10, 8, 8'h01};
`endif

        bus.start = 1'b0;
        bus.exp_e = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'(outs()), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].e, 1'b0, 0, 0, 0, 0, eoc_at, n_ldr, n_loop, l1, n_busy, frozen_bad, ro);
            check($sformatf("eoc_cycle[%0d]", i), eoc_at, vecs[i].eoc);
            check($sformatf("ld_r_pulses[%0d]", i), n_ldr, vecs[i].ldr);
            check($sformatf("loop_rounds[%0d]", i), n_loop, vecs[i].nloop);
            check($sformatf("lock1_bits[%0d]", i), int'(l1), int'(vecs[i].lock1));
            check($sformatf("busy_cycles[%0d]", i), n_busy, vecs[i].eoc);
            @(posedge clk); #1;
        end

        // Stray start mid-LOOP and stray mmm_done during a STORE cycle.
        run_op(8'h05, 1'b0, 12, 14, 0, 0, eoc_at, n_ldr, n_loop, l1, n_busy, frozen_bad, ro);
        check("stray_eoc_cycle", eoc_at, EOC_05);
        check("stray_lock1_bits", int'(l1), 5);
        @(posedge clk); #1;

        // en low for 4 cycles while waiting on the multiplier in the first LOOP round.
        run_op(8'h05, 1'b0, 0, 0, 7, 0, eoc_at, n_ldr, n_loop, l1, n_busy, frozen_bad, ro);
        check("en_pause_eoc_cycle", eoc_at, EOC_05 + 4);
        check("en_pause_frozen", frozen_bad, 0);
        @(posedge clk); #1;

        // Reset in the third LOOP round, then a fresh operation.
        run_op(8'h05, 1'b0, 0, 0, 0, 16, eoc_at, n_ldr, n_loop, l1, n_busy, frozen_bad, ro);
        check("mid_reset_outputs", int'(ro), 0);
        @(posedge clk); #1;
        run_op(8'h05, 1'b0, 0, 0, 0, 0, eoc_at, n_ldr, n_loop, l1, n_busy, frozen_bad, ro);
        check("after_reset_eoc_cycle", eoc_at, EOC_05);
        check("after_reset_lock1_bits", int'(l1), 5);

        // start held through DONE restarts from the following IDLE cycle.
        run_op(8'h01, 1'b1, 0, 0, 0, 0, eoc_at, n_ldr, n_loop, l1, n_busy, frozen_bad, ro);
        check("held_start_first_eoc", eoc_at, vecs[4].eoc);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("held_start_restart_load", int'({bus.ld_a, bus.busy}), 3);
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (bus.eoc) begin
                got = 1;
                break;
            end
        end
        check("held_start_second_eoc", got, 1);
        @(posedge clk); #1;
        check("idle_after_done", int'(outs()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

- Parametrised control unit for the Montgomery-based RSA modular exponentiation datapath.
- Sequences three phases over an external MMM (Montgomery multiplier):
  - pre-conversion,
  - one square/multiply round per exponent bit, LSB first,
  - post-conversion.
- Replaces the fixed-schedule controller: exponent width is a parameter and round length follows a start/done handshake with the multiplier, not a hard-coded cycle count.
- Adds a start/busy interface for the top-level SPI/register wrapper.

## Interface
Parameters:
- EXP_W, 16: exponent width in bits (≥ 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global clock enable; when low all state and outputs hold
- start  in  1  begin operation; sampled only in IDLE
- exp_e  in  EXP_W  exponent; captured on accepted start
- mmm_done  in  1  multiplier result valid; one-cycle pulse, honoured only in WAIT
- mmm_start  out  1  one-cycle pulse launching a multiplication
- rst_mmm  out  1  active-low multiplier clear; 0 in IDLE/DONE, 1 while busy
- ld_a  out  1  load multiplier operand registers
- ld_r  out  1  store multiplier result into datapath registers
- lock1  out  1  accumulator register update enable (qualifies ld_r)
- lock2  out  1  square register update enable (qualifies ld_r)
- sel1  out  2  operand mux: 00 pre, 01 loop, 10 post
- sel2  out  1  0 in PRE, 1 in LOOP/POST
- busy  out  1  operation in progress
- eoc  out  1  end-of-conversion, one-cycle pulse

## Operation
- Top states: IDLE, PRE, LOOP, POST, DONE.
- Every PRE/LOOP/POST round runs the substates LOAD → WAIT → STORE:
  - LOAD (1 cycle): ld_a=1, mmm_start=1.
  - WAIT: hold until mmm_done=1; the transition happens on that edge.
  - STORE (1 cycle): ld_r=1.
- IDLE:
  - start=1 captures exp_e into the shift register and resets the bit counter.
  - Next state is PRE.LOAD.
- PRE: one round; sel1=00, sel2=0, lock1=1, lock2=1.
- LOOP: EXP_W rounds; sel1=01, sel2=1, lock2=1, lock1=exp_sr[0].
  - At the end of each STORE: exp_sr shifts right by 1 (zero fill) and the counter increments.
  - When the counter reaches EXP_W, next state is POST.
- POST: one round; sel1=10, sel2=1, lock1=1, lock2=0.
- DONE (1 cycle): eoc=1, busy=1, rst_mmm=0; next state is IDLE.
- Outside their defined cycles, ld_a, ld_r and mmm_start are 0.
- lock1, lock2, sel1 and sel2 are stable for the whole round.

Boundary rules:
- start while busy: ignored.
- start held high through DONE: a new operation begins from the IDLE cycle that follows.
- mmm_done outside WAIT: ignored.
- mmm_done on the same cycle as LOAD: ignored; a round is always at least 3 cycles.
- en=0: freezes the FSM, counter and all outputs, including mmm_start. The multiplier shares en.
- rst mid-operation: on the next edge, return to IDLE with all outputs at reset values.

## Timing
- Reset values: all outputs 0; state IDLE; exp_sr=0.
- Outputs are registered; every output changes only on a clk edge.
- Round length is L+2 cycles, where L = LOAD-to-mmm_done distance in WAIT cycles (≥ 1).
- Without early exit, latency from the start-sampling edge to eoc is 1 + (EXP_W+2)·(L+2) cycles.
- busy is high from PRE.LOAD through DONE inclusive.

## Configuration
- Macro: MODEXP_EARLY_EXIT_EN.
- Defined:
  - On LOOP entry, and after each LOOP STORE, if the remaining exp_sr == 0 the FSM goes straight to POST.
  - exp_e=0 therefore runs only PRE and POST.
- Undefined: LOOP always runs exactly EXP_W rounds.

## Structure
- modexp_pkg holds:
  - state enum;
  - substate enum;
  - SEL1_PRE=2'b00, SEL1_LOOP=2'b01, SEL1_POST=2'b10.
- Sub-module modexp_round_seq:
  - implements the LOAD/WAIT/STORE handshake;
  - inputs: go, mmm_done, en;
  - outputs: ld_a, mmm_start, ld_r, round_done.
- The top level owns the phase FSM, exponent shift register and bit counter.

## Test plan
All scenarios use EXP_W=8 and a bench multiplier with L=3 (5-cycle rounds).
- Reset → all outputs 0.
- Start, exp_e=0x05, macro undefined:
  - eoc exactly 51 cycles after the start edge;
  - lock1 per LOOP round = 1,0,1,0,0,0,0,0;
  - ld_r pulses 10 times.
- Same stimulus, macro defined:
  - 3 LOOP rounds, lock1 = 1,0,1;
  - eoc at cycle 26.
- exp_e=0x00, macro defined → PRE then POST only, eoc at cycle 11. Macro undefined → eoc at cycle 51 with lock1 always 0 in LOOP.
- start pulsed mid-LOOP, plus a stray mmm_done during STORE → no effect; eoc timing unchanged.
- en low for 4 cycles inside WAIT → outputs frozen; eoc delayed by exactly 4 cycles.
- rst asserted in the third LOOP round → next cycle IDLE, all outputs 0; a fresh start afterwards completes normally.
